// File: rtl/gates_pkg.sv
// Shared types for the streaming reduction-gate block: operating mode and the
// three-bit reduction result carried between the reducer, accumulator and output register.
package gates_pkg;

    typedef enum logic {
        MODE_WORD = 1'b0,
        MODE_PKT  = 1'b1
    } gates_mode_t;

    typedef struct packed {
        logic r_and;
        logic r_or;
        logic r_xor;
    } gates_red_t;

endpackage

// File: rtl/gates_reduce_n.sv
// Combinational WIDTH-bit AND/OR/XOR reduction of one input word.
module gates_reduce_n
    import gates_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output gates_red_t       red_o
);

    assign red_o.r_and = &data_i;
    assign red_o.r_or  = |data_i;
    assign red_o.r_xor = ^data_i;

endmodule

// File: rtl/gates_reduce_stream.sv
// Streaming reduction block: accumulates AND/OR/XOR and a saturating beat count over a
// packet (or a single word) and presents the result in a handshaked output register.
module gates_reduce_stream
    import gates_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_and,
    output logic             out_or,
    output logic             out_xor,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    gates_red_t       red_s;
    gates_red_t       cmb_red_s;
    logic [CNT_W-1:0] cmb_cnt_s;
    logic             cmb_sat_s;
    logic             accept_s;
    logic             term_s;

    gates_red_t       acc_red_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic             acc_sat_q;
    logic             acc_vld_q;

    gates_red_t       out_red_q;
    logic [CNT_W-1:0] out_cnt_q;
    logic             out_sat_q;
    logic             out_vld_q;

    gates_reduce_n #(.WIDTH(WIDTH)) u_reduce (
        .data_i (in_data),
        .red_o  (red_s)
    );

    assign in_ready = !out_vld_q || out_ready;
    assign accept_s = in_valid && in_ready;
    assign term_s   = (gates_mode_t'(mode) == MODE_WORD) || in_last;

    // Combine the incoming beat with accumulated history; an empty accumulator starts fresh.
    always_comb begin
        cmb_red_s = red_s;
        cmb_cnt_s = CNT_ONE;
        cmb_sat_s = 1'b0;
        if (acc_vld_q) begin
            cmb_red_s.r_and = acc_red_q.r_and & red_s.r_and;
            cmb_red_s.r_or  = acc_red_q.r_or  | red_s.r_or;
            cmb_red_s.r_xor = acc_red_q.r_xor ^ red_s.r_xor;
            if (acc_cnt_q == CNT_MAX) begin
                cmb_cnt_s = CNT_MAX;
            end else begin
                cmb_cnt_s = acc_cnt_q + CNT_ONE;
            end
            cmb_sat_s = acc_sat_q || (cmb_cnt_s == CNT_MAX);
        end else begin
            cmb_sat_s = (CNT_ONE == CNT_MAX);
        end
    end

    // Accumulator and output register update with the valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_red_q <= '0;
            acc_cnt_q <= '0;
            acc_sat_q <= 1'b0;
            acc_vld_q <= 1'b0;
            out_red_q <= '0;
            out_cnt_q <= '0;
            out_sat_q <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            if (accept_s && term_s) begin
                out_red_q <= cmb_red_s;
                out_cnt_q <= cmb_cnt_s;
                out_sat_q <= cmb_sat_s;
                out_vld_q <= 1'b1;
                acc_vld_q <= 1'b0;
            end else if (accept_s) begin
                acc_red_q <= cmb_red_s;
                acc_cnt_q <= cmb_cnt_s;
                acc_sat_q <= cmb_sat_s;
                acc_vld_q <= 1'b1;
                if (out_ready) begin
                    out_vld_q <= 1'b0;
                end else begin
                    out_vld_q <= out_vld_q;
                end
            end else if (out_ready) begin
                out_vld_q <= 1'b0;
            end else begin
                out_vld_q <= out_vld_q;
            end
        end
    end

    assign out_and   = out_red_q.r_and;
    assign out_or    = out_red_q.r_or;
    assign out_xor   = out_red_q.r_xor;
    assign out_beats = out_cnt_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_vld_q;

endmodule

// File: tb/tb_gates_reduce_stream.sv
// Self-checking bench for gates_reduce_stream: table vectors, hand sequences and a
// randomized run against a packet-level reference model.
module tb_gates_reduce_stream;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic       out_and;
    logic       out_or;
    logic       out_xor;
    logic [7:0] out_beats;
    logic       out_sat;
    logic       out_valid;
    logic       out_ready;

    logic       b_mode;
    logic [7:0] b_in_data;
    logic       b_in_last;
    logic       b_in_valid;
    logic       b_in_ready;
    logic       b_out_and;
    logic       b_out_or;
    logic       b_out_xor;
    logic [1:0] b_out_beats;
    logic       b_out_sat;
    logic       b_out_valid;
    logic       b_out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit a;
        bit o;
        bit x;
        int n;
    } res_t;

    typedef struct {
        logic [7:0] d;
        bit         ea;
        bit         eo;
        bit         ex;
    } tvec_t;

    logic [7:0] beats_q[$];
    bit         have_out;
    res_t       cur_out;

    gates_reduce_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .out_and(out_and), .out_or(out_or),
        .out_xor(out_xor), .out_beats(out_beats), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    gates_reduce_stream #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_data(b_in_data), .in_last(b_in_last),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_and(b_out_and), .out_or(b_out_or),
        .out_xor(b_out_xor), .out_beats(b_out_beats), .out_sat(b_out_sat),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t reduce_packet(input logic [7:0] q[$]);
        res_t r;
        r.a = 1'b1;
        r.o = 1'b0;
        r.x = 1'b0;
        r.n = q.size();
        foreach (q[i]) begin
            r.a = r.a && (q[i] == 8'hFF);
            r.o = r.o || (q[i] != 8'h00);
            r.x = r.x ^ ($countones(q[i]) % 2 == 1);
        end
        return r;
    endfunction

    // One clock cycle: drive inputs, check DUT against the model, advance the model.
    task automatic cyc(input bit m, input logic [7:0] d, input bit l, input bit v,
                       input bit r, output bit acc);
        bit   term;
        bit   exp_rdy;
        res_t nres;
        mode = m; in_data = d; in_last = l; in_valid = v; out_ready = r;
        #1;
        chk("out_valid", int'(out_valid), int'(have_out));
        if (have_out) begin
            chk("out_and", int'(out_and), int'(cur_out.a));
            chk("out_or", int'(out_or), int'(cur_out.o));
            chk("out_xor", int'(out_xor), int'(cur_out.x));
            chk("out_beats", int'(out_beats), (cur_out.n > 255) ? 255 : cur_out.n);
            chk("out_sat", int'(out_sat), int'(cur_out.n >= 255));
        end
        exp_rdy = !have_out || r;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        acc  = v && exp_rdy;
        term = 1'b0;
        if (acc) begin
            beats_q.push_back(d);
            term = (m == 1'b0) || l;
            if (term) begin
                nres = reduce_packet(beats_q);
                beats_q.delete();
            end
        end
        @(posedge clk);
        if (acc && term) begin
            have_out = 1'b1;
            cur_out  = nres;
        end else if (r) begin
            have_out = 1'b0;
        end
        #1;
    endtask

    initial begin
        tvec_t tbl[6];
        bit    acc;
        int    v;
        int    guard;

        tbl[0] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h01, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{8'h03, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h7F, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{8'hA5, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; mode = 1'b0; in_data = 8'h00; in_last = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0;
        b_mode = 1'b1; b_in_data = 8'h00; b_in_last = 1'b0; b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        have_out = 1'b0;
        cur_out = '{1'b0, 1'b0, 1'b0, 0};
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_and", int'(out_and), 0);
        chk("rst_out_or", int'(out_or), 0);
        chk("rst_out_xor", int'(out_xor), 0);
        chk("rst_out_beats", int'(out_beats), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Word-mode table vectors, each checked against its hand-derived result.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, tbl[i].d, 1'b0, 1'b1, 1'b1, acc);
            chk("tbl_valid", int'(out_valid), 1);
            chk("tbl_and", int'(out_and), int'(tbl[i].ea));
            chk("tbl_or", int'(out_or), int'(tbl[i].eo));
            chk("tbl_xor", int'(out_xor), int'(tbl[i].ex));
            chk("tbl_beats", int'(out_beats), 1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Three-beat packet, then a result held under back-pressure.
        cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, acc);
        cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, acc);
        cyc(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, acc);
        chk("pkt3_beats", int'(out_beats), 3);
        chk("pkt3_xor", int'(out_xor), 1);
        cyc(1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, acc);
        cyc(1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, acc);
        cyc(1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, acc);
        chk("drain_accept", int'(acc), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Mode switched to word mid-packet terminates with history.
        cyc(1'b1, 8'h10, 1'b0, 1'b1, 1'b1, acc);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        chk("switch_beats", int'(out_beats), 2);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Reset mid-packet discards partial history.
        cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, acc);
        cyc(1'b1, 8'h07, 1'b0, 1'b1, 1'b1, acc);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        have_out = 1'b0;
        beats_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, acc);
        chk("postrst_valid", int'(out_valid), 1);
        chk("postrst_beats", int'(out_beats), 1);
        chk("postrst_or", int'(out_or), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Saturating counter on the narrow-count instance.
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1'b1; b_in_data = 8'h80; b_in_last = (i == 4);
            @(posedge clk);
            #1;
            if (i < 4) chk("sat_early_valid", int'(b_out_valid), 0);
        end
        b_in_valid = 1'b0;
        chk("sat_valid", int'(b_out_valid), 1);
        chk("sat_beats", int'(b_out_beats), 3);
        chk("sat_flag", int'(b_out_sat), 1);
        chk("sat_and", int'(b_out_and), 0);
        chk("sat_or", int'(b_out_or), 1);
        chk("sat_xor", int'(b_out_xor), 1);

        // Word-mode sweep of every value with random back-pressure.
        v = 0;
        guard = 0;
        while (v < 256 && guard < 5000) begin
            cyc(1'b0, 8'(v), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), acc);
            if (acc) v++;
            guard++;
        end
        chk("sweep_done", v, 256);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Fully random mixed traffic, including long packets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) != 0), 8'($urandom), ($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), acc);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
